// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, and load results drain
// through a small in-order queue. Loads are formatted at enqueue and killed on a WAW hazard.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ALU_VALID,
  input  logic [4:0]                 ALU_RD,
  input  logic [XLEN-1:0]            ALU_DATA,
  input  logic                       LD_VALID,
  output logic                       LD_READY,
  input  logic [4:0]                 LD_RD,
  input  logic [2:0]                 LD_FUNCT3,
  input  logic [1:0]                 LD_ADDR_LO,
  input  logic [XLEN-1:0]            LD_WORD,
  output logic [4:0]                 A3,
  output logic [XLEN-1:0]            WD3,
  output logic                       EN,
  output logic [31:0]                PENDING,
  output logic [$clog2(DEPTH+1)-1:0] LQ_COUNT
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic            live_q [DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            en_q;
  logic [4:0]      a3_q;
  logic [XLEN-1:0] wd3_q;

  logic            alu_eff, ld_enq, pop;
  logic [XLEN-1:0] ld_fmt;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     pend;

  assign LD_READY = (cnt_q < CW'(DEPTH));
  assign alu_eff  = ALU_VALID && (ALU_RD != 5'd0);
  assign ld_enq   = LD_VALID && LD_READY && (LD_RD != 5'd0);
  assign pop      = !alu_eff && (cnt_q != '0);

  assign ld_byte = LD_WORD[{LD_ADDR_LO, 3'b000} +: 8];
  assign ld_half = LD_WORD[{LD_ADDR_LO[1], 4'b0000} +: 16];

  always_comb begin
    ld_fmt = LD_WORD;
    case (LD_FUNCT3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = LD_WORD;
    endcase
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_q[i]) pend[rd_q[i]] = 1'b1;
    pend[0] = 1'b0;
  end

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        live_q[i] <= 1'b0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (alu_eff && live_q[i] && rd_q[i] == ALU_RD) live_q[i] <= 1'b0;
      if (pop) begin
        live_q[rptr_q] <= 1'b0;
        rptr_q         <= inc_ptr(rptr_q);
      end
      // A load arriving alongside an ALU write to the same rd is the older write.
      if (ld_enq) begin
        rd_q[wptr_q]   <= LD_RD;
        data_q[wptr_q] <= ld_fmt;
        live_q[wptr_q] <= !(alu_eff && ALU_RD == LD_RD);
        wptr_q         <= inc_ptr(wptr_q);
      end
      if (ld_enq && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!ld_enq && pop) cnt_q <= cnt_q - 1'b1;

      if (alu_eff) begin
        en_q  <= 1'b1;
        a3_q  <= ALU_RD;
        wd3_q <= ALU_DATA;
      end else if (pop && live_q[rptr_q]) begin
        en_q  <= 1'b1;
        a3_q  <= rd_q[rptr_q];
        wd3_q <= data_q[rptr_q];
      end else begin
        en_q  <= 1'b0;
      end
    end
  end

  assign EN       = en_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign PENDING  = pend;
  assign LQ_COUNT = cnt_q;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter driving the single register-file write port (A3/WD3/EN) of the RV32 core. It merges ALU results, which have priority, with load results from the LSU. Load results pass through a small in-order queue and are byte/half-extracted and extended per funct3. It also exports a pending-register mask for the hazard unit.

## Interface
- DEPTH, 2, load queue entries (>=1)
- XLEN, 32, datapath width

- CLK  in  1  global clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ALU_VALID  in  1  ALU result present this cycle (always accepted, no ready)
- ALU_RD  in  5  ALU destination register
- ALU_DATA  in  XLEN  ALU result
- LD_VALID  in  1  load result offered
- LD_READY  out  1  queue can accept; transfer when LD_VALID && LD_READY at rising CLK
- LD_RD  in  5  load destination register
- LD_FUNCT3  in  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
- LD_ADDR_LO  in  2  effective address bits [1:0]
- LD_WORD  in  XLEN  raw aligned memory word
- A3  out  5  register-file write address (registered)
- WD3  out  XLEN  register-file write data (registered)
- EN  out  1  register-file write enable (registered)
- PENDING  out  32  bit r set when a live queued load targets xr; bit 0 always 0
- LQ_COUNT  out  $clog2(DEPTH+1)  queue occupancy (live plus killed entries)

## Operation
- Reset: EN=0, A3=0, WD3=0, queue empty, LQ_COUNT=0, PENDING=0, LD_READY=1.
- LD_READY = (LQ_COUNT < DEPTH). This is combinational from the count only. A pop in the same cycle does not make a full queue ready.
- Load formatting is applied at enqueue, and the formatted value is stored.
  - LB/LBU: byte LD_ADDR_LO of LD_WORD, sign- or zero-extended.
  - LH/LHU: halfword LD_ADDR_LO[1]; LD_ADDR_LO[0] is ignored.
  - LW and all reserved funct3 codes: LD_WORD unchanged.
- A load with LD_RD=0 is accepted (handshake completes) but is not enqueued.
- An ALU result is effective when ALU_VALID=1 and ALU_RD!=0. ALU_RD=0 is treated as ALU_VALID=0.
- Per-cycle selection, registered into A3/WD3/EN at the rising edge:
  - Effective ALU result: EN=1, A3=ALU_RD, WD3=ALU_DATA. The queue does not pop.
  - Otherwise, queue non-empty: pop the head. If the head is live, EN=1 with its rd/data. If killed, EN=0.
  - Otherwise: EN=0. A3/WD3 hold their previous values.
- WAW kill: an effective ALU write to rd X marks every live queued entry with rd X as killed.
- A load accepted in the same cycle as an effective ALU write to the same rd is older than the ALU write. It is enqueued already killed.
- Killed entries keep their slot until popped and do not contribute to PENDING.
- PENDING is combinational: the OR of one-hot(rd) over live entries.
- Enqueue and pop in the same cycle leave LQ_COUNT unchanged. Pointers wrap modulo DEPTH.

## Timing
- ALU path: inputs sampled at edge N, EN/A3/WD3 valid after edge N, register file commits at edge N+1.
- Load path, idle ALU, empty queue: accepted at edge N, popped at edge N+1 (outputs valid after N+1), committed at edge N+2.
- A continuous ALU stream starves the queue. LD_READY drops once the queue is full. There is no fairness guarantee.
- PENDING reflects an enqueue or kill in the cycle after the edge that caused it. A bit clears after the pop edge.
- RST asserted mid-operation immediately clears the queue, count and outputs, including in-flight entries. There is no partial write after reset.

## Test plan
- Reset: assert RST mid-stream with 2 entries queued → EN=0, A3=0, WD3=0, LQ_COUNT=0, PENDING=0, LD_READY=1 before the next edge.
- ALU write: ALU_VALID=1, ALU_RD=5, ALU_DATA=0x12345678 at edge N → after N: EN=1, A3=5, WD3=0x12345678. ALU_RD=0 → EN=0.
- Load extract, LD_WORD=0x80FF7F01:
  - LB, ADDR_LO=2 → WD3=0xFFFFFFFF
  - LBU, ADDR_LO=3 → 0x00000080
  - LH, ADDR_LO=2 → 0xFFFF80FF
  - LHU, ADDR_LO=0 → 0x00007F01
  - Each write appears 2 cycles after acceptance.
- Backpressure, DEPTH=2: hold ALU_VALID=1 (rd 1) and offer 3 loads to rd 7, 8, 9.
  - Required: two accepted, LD_READY=0, PENDING=0x180.
  - After ALU stops: writes to x7 then x8 on consecutive cycles, then x9 is accepted.
- WAW kill: load to x4 queued, then ALU write x4=0xAA → PENDING[4]=0, the popped entry gives EN=0, and x4 finally holds 0xAA. The same rule holds with load and ALU in the same cycle.
- Concurrent enqueue/pop: with 1 entry queued, ALU idle, and a new load accepted → LQ_COUNT stays 1 and the head is written. Pointer wrap is verified over 5 loads.
